// File: rtl/regfile_scoreboard_pkg.sv
// Shared core package for the register file / scoreboard slice.
// Holds the default geometry and the register-address type.
package regfile_scoreboard_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_busy_table.sv
// One pending bit per register: set at issue of a long-latency op,
// cleared by its write-back, queried on three addresses.
module regfile_busy_table #(
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] q1_addr,
  input  logic [AW-1:0] q2_addr,
  input  logic [AW-1:0] qd_addr,
  output logic          q1,
  output logic          q2,
  output logic          qd
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  // Next state: clear first, then set, so a new issue overrides a retiring op
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    if (ZR)     busy_nxt[0]        = 1'b0;
  end

  // Busy state register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Queries come from current state only; no same-cycle clear forwarding
  always_comb begin
    q1 = busy[q1_addr];
    q2 = busy[q2_addr];
    qd = busy[qd_addr];
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write / two-read register file with a busy scoreboard for
// long-latency write-back. Optional same-cycle write forwarding to the
// read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  input  logic            we0,
  input  logic [AW-1:0]   rd0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   rd1,
  input  logic [XLEN-1:0] wd1,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            busyd
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] mem [NREGS];

  // Array write: port 1 first, port 0 after it so port 0 wins a collision
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (we1 && !(ZR && rd1 == '0)) mem[rd1] <= wd1;
      if (we0 && !(ZR && rd0 == '0)) mem[rd0] <= wd0;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] v;
`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by reset so reads stay zero while it is held
    if (!RST && we0 && addr == rd0)      v = wd0;
    else if (!RST && we1 && addr == rd1) v = wd1;
    else                                 v = mem[addr];
`else
    v = mem[addr];
`endif
    if (ZR && addr == '0) v = '0;
    return v;
  endfunction

  // Combinational read ports
  always_comb begin
    a = rd_port(rs1);
    b = rd_port(rs2);
  end

  regfile_busy_table #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk      (CLK),
    .rst      (RST),
    .set_en   (busy_set),
    .set_addr (busy_rd),
    .clr_en   (we1),
    .clr_addr (rd1),
    .q1_addr  (rs1),
    .q2_addr  (rs2),
    .qd_addr  (busy_rd),
    .q1       (busy1),
    .q2       (busy2),
    .qd       (busyd)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default geometry).
// Expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  reg_addr_t   rs1, rs2, rd0, rd1, busy_rd;
  logic [31:0] a, b, wd0, wd1;
  logic        we0, we1, busy_set;
  logic        busy1, busy2, busyd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .rs1(rs1), .rs2(rs2), .a(a), .b(b),
    .we0(we0), .rd0(rd0), .wd0(wd0), .we1(we1), .rd1(rd1), .wd1(wd1),
    .busy_set(busy_set), .busy_rd(busy_rd),
    .busy1(busy1), .busy2(busy2), .busyd(busyd)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and drop all strobes
  task automatic tick();
    @(posedge CLK);
    #1;
    we0 = 1'b0; we1 = 1'b0; busy_set = 1'b0;
  endtask

  initial begin
    RST = 1'b1; rs1 = '0; rs2 = '0; rd0 = '0; rd1 = '0; busy_rd = '0;
    wd0 = '0; wd1 = '0; we0 = 1'b0; we1 = 1'b0; busy_set = 1'b0;
    #1;
    check("reset_a", a, 32'h0);
    check("reset_busy", {29'd0, busy1, busy2, busyd}, 32'h0);
    tick();
    RST = 1'b0;

    // x5 <= DEADBEEF and mark x5 busy
    we0 = 1'b1; rd0 = 5'd5; wd0 = 32'hDEADBEEF;
    busy_set = 1'b1; busy_rd = 5'd5;
    tick();
    rs1 = 5'd5; #1;
    check("x5_write", a, 32'hDEADBEEF);
    check("x5_busy", {31'd0, busy1}, 32'h1);

    // Mid-cycle reset clears immediately
    #1 RST = 1'b1; #1;
    check("rst_async_a", a, 32'h0);
    check("rst_async_busy1", {31'd0, busy1}, 32'h0);
    // Writes and busy_set ignored while in reset
    we0 = 1'b1; rd0 = 5'd6; wd0 = 32'h66; busy_set = 1'b1; busy_rd = 5'd6;
    rs2 = 5'd6; #1;
    check("rst_hold_b", b, 32'h0);
    check("rst_hold_busyd", {31'd0, busyd}, 32'h0);
    tick();
    RST = 1'b0; #1;
    check("rst_ignored_write", b, 32'h0);
    check("rst_ignored_busy", {31'd0, busy2}, 32'h0);

    // In-flight op discarded by reset; its write-back still writes data
    we1 = 1'b1; rd1 = 5'd5; wd1 = 32'h77;
    tick();
    check("wb_after_rst", a, 32'h77);
    check("wb_after_rst_busy", {31'd0, busy1}, 32'h0);

    // Zero register
    rs1 = 5'd0; we0 = 1'b1; rd0 = 5'd0; wd0 = 32'h1234; #1;
    check("x0_same_cycle", a, 32'h0);
    tick();
    check("x0_write", a, 32'h0);
    busy_set = 1'b1; busy_rd = 5'd0;
    tick();
    check("x0_busy", {29'd0, busy1, busy2, busyd}, 32'h0);

    // Write collision on x7: port 0 wins
    we0 = 1'b1; rd0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; rd1 = 5'd7; wd1 = 32'h22;
    tick();
    rs2 = 5'd7; #1;
    check("collision_x7", b, 32'h11);

    // Scoreboard set then clear by write-back
    busy_set = 1'b1; busy_rd = 5'd9;
    tick();
    rs1 = 5'd9; #1;
    check("sb_busy1", {31'd0, busy1}, 32'h1);
    check("sb_busyd", {31'd0, busyd}, 32'h1);
    we1 = 1'b1; rd1 = 5'd9; wd1 = 32'h55; #1;
    check("sb_no_fwd_clear", {31'd0, busy1}, 32'h1);
    tick();
    check("sb_cleared", {31'd0, busy1}, 32'h0);
    check("sb_wb_data", a, 32'h55);

    // Set/clear race on x3: set wins
    busy_set = 1'b1; busy_rd = 5'd3;
    we1 = 1'b1; rd1 = 5'd3; wd1 = 32'h33;
    tick();
    rs2 = 5'd3; #1;
    check("race_busy", {31'd0, busy2}, 32'h1);
    check("race_data", b, 32'h33);
    we1 = 1'b1; rd1 = 5'd3; wd1 = 32'h34;
    tick();
    check("race_clear", {31'd0, busy2}, 32'h0);

    // we0 never touches busy bits
    busy_set = 1'b1; busy_rd = 5'd10;
    tick();
    we0 = 1'b1; rd0 = 5'd10; wd0 = 32'h1;
    tick();
    rs1 = 5'd10; #1;
    check("we0_keeps_busy", {31'd0, busy1}, 32'h1);
    check("we0_data", a, 32'h1);

    // Bypass behaviour on x4
    we0 = 1'b1; rd0 = 5'd4; wd0 = 32'h10;
    tick();
    rs1 = 5'd4; rs2 = 5'd4;
    we0 = 1'b1; rd0 = 5'd4; wd0 = 32'hA5; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_wd0", a, 32'hA5);
`else
    check("bypass_wd0", a, 32'h10);
`endif
    tick();
    check("after_wd0", a, 32'hA5);
    we1 = 1'b1; rd1 = 5'd4; wd1 = 32'hBB; #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_wd1", b, 32'hBB);
`else
    check("bypass_wd1", b, 32'hA5);
`endif
    tick();
    check("after_wd1", b, 32'hBB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count (power of two, >=2); AW = log2(NREGS) is derived.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have ports rs1, rs2  input  AW  meaning read addresses.
REQ-007 SHALL have ports a, b  output  XLEN  meaning read data for rs1 and rs2.
REQ-008 SHALL have ports we0, rd0, wd0  input  1/AW/XLEN  meaning single-cycle (ALU) write port.
REQ-009 SHALL have ports we1, rd1, wd1  input  1/AW/XLEN  meaning long-latency (mul/div) write-back port; it also clears busy.
REQ-010 SHALL have ports busy_set, busy_rd  input  1/AW  meaning mark busy_rd pending at issue of a long-latency op.
REQ-011 SHALL have ports busy1, busy2, busyd  output  1  meaning pending status of rs1, rs2 and busy_rd (combinational).

Function
REQ-012 SHALL read a and b combinationally from the array; latency zero.
REQ-013 SHALL write wd0 to rd0 when we0, and wd1 to rd1 when we1, at the rising CLK edge.
REQ-014 SHALL, when we0 and we1 target the same register in one cycle, store wd0 (port 0 wins).
REQ-015 SHALL, with ZERO_REG=1, ignore writes to register 0, return 0 on reads of it, and never report it busy.
REQ-016 SHALL keep one busy bit per register; busy_set sets busy[busy_rd] at the edge.
REQ-017 SHALL clear busy[rd1] at the edge when we1 is high.
REQ-018 SHALL leave the bit set when busy_set and the we1 clear hit the same register in the same cycle (set wins: new issue).
REQ-019 SHALL NOT let a we0 write change any busy bit.
REQ-020 SHALL drive busy1 = busy[rs1], busy2 = busy[rs2] and busyd = busy[busy_rd] from current state, without same-cycle clear forwarding.

Reset
REQ-021 SHALL, while RST is high, clear every register and every busy bit immediately and regardless of CLK.
REQ-022 SHALL hold a=0, b=0 and busy1/busy2/busyd=0 during reset; writes and busy_set are ignored.
REQ-023 SHALL discard a long-latency op in flight across reset; its later we1 writes data normally.

Configuration
REQ-024 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to a/b: wd0 if we0 and rd0 matches, else wd1 if we1 and rd1 matches, else array; zero register excluded.
REQ-025 SHALL, with REGFILE_BYPASS_EN undefined, return array contents only; a same-cycle write is visible from the next cycle.

Structure
REQ-026 SHALL place the default XLEN and NREGS constants and the register-address typedef in the shared core package.
REQ-027 SHALL implement the busy-bit array as sub-module regfile_busy_table (set/clear/query), instantiated once.

Verification
REQ-028 SHALL cover reset: write 0xDEADBEEF to x5, assert RST mid-cycle -> a=0 for rs1=5 immediately, busy1=0.
REQ-029 SHALL cover zero register: we0 rd0=0 wd0=0x1234 -> rs1=0 reads 0; busy_set busy_rd=0 -> busyd=0.
REQ-030 SHALL cover write collision: we0 and we1 both to x7 with 0x11 and 0x22 -> x7=0x11 next cycle.
REQ-031 SHALL cover scoreboard: busy_set x9 -> busy1=1 for rs1=9 next cycle; we1 rd1=9 wd1=0x55 -> busy1=0 and a=0x55 after edge.
REQ-032 SHALL cover set/clear race: busy_set x3 and we1 rd1=3 same cycle -> busy[3]=1 after edge.
REQ-033 SHALL cover bypass: we0 rd0=4 wd0=0xA5, rs1=4 same cycle -> a=0xA5 with REGFILE_BYPASS_EN, old value without.
